spi_xfer_ctl: RTL and testbench

Transfer controller that sits directly upstream of the SPI master and also consumes the master's results.
- Generates the master's bit-rate strobes (proc_en, proc_en_p).
- Buffers host TX words in a FIFO, hands them to the master one frame at a time through r_spi_en/r_spi_nf/r_spi_txd, and handshakes on r_spi_txstrt/r_spi_txdone.
- Captures each received word r_spi_rxd into an RX FIFO for the host.

---
 rtl/spi_xfer_ctl.sv | 212 +++++++++++++++++++++
 tb/tb_spi_xfer_ctl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctl.sv
// SPI transfer controller: bit-rate strobes for the master, TX/RX word FIFOs
// and the frame handshake sequencer between them.
//
// state  | meaning
// S_IDLE | no frame pending; waits for enable, a TX word and RX room
// S_ARM  | r_spi_nf low, waiting for the master's frame-start pulse
// S_BUSY | master shifting the frame, waiting for frame-done pulse
// S_CAPT | push received word into RX FIFO, count the frame
module spi_xfer_ctl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_en,
    input  logic [7:0]    cfg_div,
    input  logic          wr_en,
    input  logic [31:0]   wr_data,
    output logic          wr_full,
    input  logic          rd_en,
    output logic [31:0]   rd_data,
    output logic          rd_empty,
    output logic [AW:0]   tx_level,
    output logic [AW:0]   rx_level,
    output logic          busy,
    output logic          err_ovf,
    output logic          err_udf,
    output logic [15:0]   xfer_cnt,
    output logic          proc_en,
    output logic          proc_en_p,
    output logic          r_spi_en,
    output logic          r_spi_nf,
    output logic [31:0]   r_spi_txd,
    input  logic [31:0]   r_spi_rxd,
    input  logic          r_spi_txstrt,
    input  logic          r_spi_txdone
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_BUSY, S_CAPT} state_t;

    state_t        state_q;
    logic          nf_q;
    logic          busy_q;
    logic          spi_en_q;
    logic [15:0]   xfer_cnt_q;
    logic          err_ovf_q;
    logic          err_udf_q;

    logic [7:0]    div_sel;
    logic [7:0]    div_cnt_q, div_cnt_d;
    logic [7:0]    div_lim_q, div_lim_d;
    logic          proc_en_q, proc_en_p_q;

    logic [31:0]   tx_mem_q [DEPTH];
    logic [AW-1:0] tx_wptr_q, tx_rptr_q;
    logic [AW:0]   tx_level_q;
    logic          tx_full, tx_push, tx_pop;

    logic [31:0]   rx_mem_q [DEPTH];
    logic [AW-1:0] rx_wptr_q, rx_rptr_q;
    logic [AW:0]   rx_level_q;
    logic          rx_empty, rx_push, rx_pop;

    // Strobe generator: limit (P-1) is only reloaded at the wrap, so a
    // cfg_div change never truncates a period already in progress.
    assign div_sel = (cfg_div == 8'd0) ? 8'd1 : cfg_div;

    always_comb begin
        div_cnt_d = div_cnt_q + 8'd1;
        div_lim_d = div_lim_q;
        if (div_cnt_q == div_lim_q) begin
            div_cnt_d = '0;
            div_lim_d = div_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q   <= '0;
            div_lim_q   <= div_sel;
            proc_en_q   <= 1'b0;
            proc_en_p_q <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            div_lim_q   <= div_lim_d;
            proc_en_q   <= (div_cnt_d == div_lim_d);
            proc_en_p_q <= (div_cnt_d == div_lim_d - 8'd1);
        end
    end

    assign tx_full  = (tx_level_q == FULL_LVL);
    assign tx_pop   = (state_q == S_ARM) && r_spi_txstrt;
    assign tx_push  = wr_en && (!tx_full || tx_pop);

    assign rx_empty = (rx_level_q == '0);
    assign rx_push  = (state_q == S_CAPT);
    assign rx_pop   = rd_en && !rx_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) tx_mem_q[i] <= '0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_level_q <= '0;
        end else begin
            if (tx_push) begin
                tx_mem_q[tx_wptr_q] <= wr_data;
                tx_wptr_q           <= tx_wptr_q + 1'b1;
            end
            if (tx_pop) tx_rptr_q <= tx_rptr_q + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_level_q <= tx_level_q + 1'b1;
                2'b01:   tx_level_q <= tx_level_q - 1'b1;
                default: tx_level_q <= tx_level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) rx_mem_q[i] <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_level_q <= '0;
        end else begin
            if (rx_push) begin
                rx_mem_q[rx_wptr_q] <= r_spi_rxd;
                rx_wptr_q           <= rx_wptr_q + 1'b1;
            end
            if (rx_pop) rx_rptr_q <= rx_rptr_q + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_level_q <= rx_level_q + 1'b1;
                2'b01:   rx_level_q <= rx_level_q - 1'b1;
                default: rx_level_q <= rx_level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            if (wr_en && !tx_push) err_ovf_q <= 1'b1;
            if (rd_en && rx_empty) err_udf_q <= 1'b1;
        end
    end

    // A start pulse wins over a simultaneous enable drop: the master has
    // already latched the head word, so the frame must be tracked to the end.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            nf_q       <= 1'b1;
            busy_q     <= 1'b0;
            spi_en_q   <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            spi_en_q <= cfg_en;
            case (state_q)
                S_IDLE: begin
                    if (cfg_en && (tx_level_q != '0) && (rx_level_q < FULL_LVL)) begin
                        state_q <= S_ARM;
                        nf_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_ARM: begin
                    if (r_spi_txstrt) begin
                        state_q <= S_BUSY;
                        nf_q    <= 1'b1;
                    end else if (!cfg_en) begin
                        state_q <= S_IDLE;
                        nf_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (r_spi_txdone) state_q <= S_CAPT;
                end
                S_CAPT: begin
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                    xfer_cnt_q <= xfer_cnt_q + 16'd1;
                end
                default: begin
                    state_q <= S_IDLE;
                    nf_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_full   = tx_full;
    assign rd_empty  = rx_empty;
    assign rd_data   = rx_mem_q[rx_rptr_q];
    assign r_spi_txd = tx_mem_q[tx_rptr_q];
    assign tx_level  = tx_level_q;
    assign rx_level  = rx_level_q;
    assign busy      = busy_q;
    assign err_ovf   = err_ovf_q;
    assign err_udf   = err_udf_q;
    assign xfer_cnt  = xfer_cnt_q;
    assign proc_en   = proc_en_q;
    assign proc_en_p = proc_en_p_q;
    assign r_spi_en  = spi_en_q;
    assign r_spi_nf  = nf_q;

endmodule

// File: tb/tb_spi_xfer_ctl.sv
// Bench for spi_xfer_ctl: loopback SPI master model, queue-based reference
// model compared every cycle, plus directed scenarios with literal values.
module tb_spi_xfer_ctl;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int PH_IDLE = 0, PH_ARM = 1, PH_FRAME = 2, PH_CAPT = 3;

    logic          clk = 1'b0;
    logic          rst, cfg_en, wr_en, rd_en;
    logic [7:0]    cfg_div;
    logic [31:0]   wr_data;
    logic          wr_full, rd_empty, busy, err_ovf, err_udf;
    logic [31:0]   rd_data, r_spi_txd;
    logic [AW:0]   tx_level, rx_level;
    logic [15:0]   xfer_cnt;
    logic          proc_en, proc_en_p, r_spi_en, r_spi_nf;
    logic [31:0]   rxd;
    logic          txstrt, txdone;

    spi_xfer_ctl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_div(cfg_div),
        .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
        .tx_level(tx_level), .rx_level(rx_level), .busy(busy),
        .err_ovf(err_ovf), .err_udf(err_udf), .xfer_cnt(xfer_cnt),
        .proc_en(proc_en), .proc_en_p(proc_en_p), .r_spi_en(r_spi_en),
        .r_spi_nf(r_spi_nf), .r_spi_txd(r_spi_txd), .r_spi_rxd(rxd),
        .r_spi_txstrt(txstrt), .r_spi_txdone(txdone)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // SPI master model: starts on a pre-strobe while enabled and offered a
    // frame, runs fl bit strobes, then echoes the word back (loopback).
    int          fl = 2;
    int          m_bits;
    bit          m_active = 0;
    logic [31:0] m_word;
    int          m_starts = 0, m_dones = 0;

    initial begin
        txstrt = 1'b0;
        txdone = 1'b0;
        rxd    = '0;
        forever begin
            step();
            txstrt = 1'b0;
            txdone = 1'b0;
            if (!m_active) begin
                if (r_spi_en === 1'b1 && r_spi_nf === 1'b0 && proc_en_p === 1'b1) begin
                    txstrt   = 1'b1;
                    m_word   = r_spi_txd;
                    m_bits   = fl;
                    m_active = 1;
                    m_starts++;
                end
            end else if (proc_en === 1'b1) begin
                m_bits--;
                if (m_bits == 0) begin
                    txdone   = 1'b1;
                    rxd      = m_word;
                    m_active = 0;
                    m_dones++;
                end
            end
        end
    end

    // Reference model: FIFOs as queues, frame progress as a phase number.
    logic [31:0] m_tx[$];
    logic [31:0] m_rx[$];
    int          m_ph = PH_IDLE;
    bit          m_ovf = 0, m_udf = 0, m_en = 0;
    logic [15:0] m_cnt = '0;

    always @(posedge clk) begin : model
        bit pop_t, push_t;
        int ts, rs;
        if (rst) begin
            m_tx.delete();
            m_rx.delete();
            m_ph  = PH_IDLE;
            m_ovf = 0;
            m_udf = 0;
            m_en  = 0;
            m_cnt = '0;
        end else begin
            ts     = m_tx.size();
            rs     = m_rx.size();
            pop_t  = (m_ph == PH_ARM) && txstrt;
            push_t = wr_en && (ts < DEPTH || pop_t);
            if (wr_en && !push_t) m_ovf = 1;
            if (rd_en && rs == 0) m_udf = 1;
            if (pop_t) void'(m_tx.pop_front());
            if (push_t) m_tx.push_back(wr_data);
            if (rd_en && rs > 0) void'(m_rx.pop_front());
            if (m_ph == PH_CAPT) begin
                m_rx.push_back(rxd);
                m_cnt = m_cnt + 16'd1;
            end
            m_en = cfg_en;
            case (m_ph)
                PH_IDLE:  if (cfg_en && ts != 0 && rs < DEPTH) m_ph = PH_ARM;
                PH_ARM:   if (txstrt) m_ph = PH_FRAME; else if (!cfg_en) m_ph = PH_IDLE;
                PH_FRAME: if (txdone) m_ph = PH_CAPT;
                default:  m_ph = PH_IDLE;
            endcase
        end
    end

    // Per-cycle compare, including strobe spacing and pre-strobe alignment.
    int  cyc = 0, last_en = 0, exp_gap = 0;
    bit  synced = 0;
    logic p_prev = 1'b0;

    always @(negedge clk) begin
        if (chk_on) begin
            cyc++;
            chk("tx_level", tx_level, m_tx.size());
            chk("rx_level", rx_level, m_rx.size());
            chk("wr_full", wr_full, m_tx.size() == DEPTH);
            chk("rd_empty", rd_empty, m_rx.size() == 0);
            chk("r_spi_nf", r_spi_nf, m_ph != PH_ARM);
            chk("busy", busy, m_ph != PH_IDLE);
            chk("err_ovf", err_ovf, m_ovf);
            chk("err_udf", err_udf, m_udf);
            chk("xfer_cnt", xfer_cnt, m_cnt);
            chk("r_spi_en", r_spi_en, m_en);
            if (m_tx.size() > 0) chk("r_spi_txd", r_spi_txd, m_tx[0]);
            if (m_rx.size() > 0) chk("rd_data", rd_data, m_rx[0]);
            if (rst) begin
                synced = 0;
            end else begin
                if (synced) chk("proc_en_p_lead", p_prev, proc_en);
                if (proc_en) begin
                    if (synced) chk("proc_en_gap", cyc - last_en, exp_gap);
                    synced  = 1;
                    last_en = cyc;
                    exp_gap = ((cfg_div == 0) ? 1 : int'(cfg_div)) + 1;
                end
            end
            p_prev = proc_en_p;
        end
    end

    task automatic measure_gap(output int gap);
        int n, c0;
        n = 0;
        while (proc_en !== 1'b1 && n < 64) begin step(); n++; end
        c0 = n;
        step();
        n++;
        while (proc_en !== 1'b1 && n < 64) begin step(); n++; end
        gap = n - c0;
    endtask

    task automatic push_word(input logic [31:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wait_xfer(input int target, input int budget);
        int n = 0;
        while (xfer_cnt != 16'(target) && n < budget) begin step(); n++; end
        chk("xfer_cnt_reached", xfer_cnt, target);
    endtask

    initial begin
        logic [31:0] w[9];
        logic [31:0] exp_rd[8];
        int g, s0, d0, n;

        rst = 1'b1; cfg_en = 1'b0; cfg_div = 8'd3;
        wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        step();
        chk_on = 1;
        step();
        step();
        chk("rst_nf", r_spi_nf, 1);
        chk("rst_rd_empty", rd_empty, 1);
        chk("rst_wr_full", wr_full, 0);
        chk("rst_proc_en", {proc_en, proc_en_p}, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_txd", r_spi_txd, 0);
        rst = 1'b0;

        measure_gap(g); chk("gap_div3_a", g, 4);
        measure_gap(g); chk("gap_div3_b", g, 4);
        cfg_div = 8'd0;
        measure_gap(g); chk("gap_div0_a", g, 2);
        measure_gap(g); chk("gap_div0_b", g, 2);
        cfg_div = 8'd1;

        s0 = m_starts; d0 = m_dones;
        push_word(32'hA5A5A5A5);
        cfg_en = 1'b1;
        wait_xfer(1, 100);
        step();
        chk("a5_rd_data", rd_data, 32'hA5A5A5A5);
        chk("a5_rd_empty", rd_empty, 0);
        chk("a5_tx_level", tx_level, 0);
        chk("a5_starts", m_starts - s0, 1);
        chk("a5_dones", m_dones - d0, 1);
        rd_en = 1'b1; step(); rd_en = 1'b0;

        cfg_en = 1'b0;
        step();
        for (int i = 0; i < 9; i++) begin
            w[i] = 32'h5000_0000 | (i * 32'h0011_0101);
            push_word(w[i]);
        end
        step();
        chk("ovf_wr_full", wr_full, 1);
        chk("ovf_tx_level", tx_level, 8);
        chk("ovf_err", err_ovf, 1);
        cfg_en = 1'b1;
        wait_xfer(9, 400);
        step();
        chk("full_rx_level", rx_level, 8);

        push_word(32'hC0DE0001);
        push_word(32'hC0DE0002);
        for (int i = 0; i < 40; i++) step();
        chk("rxfull_nf", r_spi_nf, 1);
        chk("rxfull_xfer", xfer_cnt, 9);
        chk("rxfull_tx_level", tx_level, 2);
        rd_en = 1'b1; step(); rd_en = 1'b0;
        wait_xfer(10, 100);
        for (int i = 0; i < 30; i++) step();
        chk("one_more_xfer", xfer_cnt, 10);
        chk("one_more_tx_level", tx_level, 1);
        chk("one_more_rx_level", rx_level, 8);

        cfg_en = 1'b0;
        for (int i = 0; i < 7; i++) exp_rd[i] = w[i+1];
        exp_rd[7] = 32'hC0DE0001;
        for (int i = 0; i < 8; i++) begin
            chk("rx_order", rd_data, exp_rd[i]);
            rd_en = 1'b1; step(); rd_en = 1'b0;
        end
        chk("drained_empty", rd_empty, 1);

        rd_en = 1'b1; step(); rd_en = 1'b0; step();
        chk("udf_flag", err_udf, 1);
        chk("udf_empty", rd_empty, 1);
        rst = 1'b1; step(); rst = 1'b0; step();
        chk("udf_cleared", err_udf, 0);
        chk("rst_tx_level", tx_level, 0);

        cfg_div = 8'd3; fl = 6;
        s0 = m_starts;
        push_word(32'hDEADBEEF);
        cfg_en = 1'b1;
        n = 0;
        while (m_starts == s0 && n < 100) begin step(); n++; end
        chk("busy_started", m_starts - s0, 1);
        step();
        chk("busy_state", busy, 1);
        rst = 1'b1; step(); rst = 1'b0; step();
        chk("abort_nf", r_spi_nf, 1);
        chk("abort_levels", {tx_level, rx_level}, 0);
        n = 0;
        while (m_active && n < 200) begin step(); n++; end
        chk("stale_done_seen", m_active, 0);
        for (int i = 0; i < 5; i++) step();
        chk("stale_xfer", xfer_cnt, 0);
        chk("stale_rx_level", rx_level, 0);

        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) cfg_div = 8'($urandom_range(0, 3));
            cfg_en  = ($urandom_range(0, 9) != 0);
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_data = $urandom();
            rd_en   = ($urandom_range(0, 3) == 0);
            rst     = ($urandom_range(0, 599) == 0);
            fl      = $urandom_range(1, 3);
            step();
        end
        cfg_en = 1'b0; wr_en = 1'b0; rd_en = 1'b0; rst = 1'b0;
        for (int i = 0; i < 20; i++) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
